// File: rtl/rnd_share_arbiter_if.sv
// Bundle of requester, rounder and result signals for the shared FP rounder arbiter.
// The slave view belongs to the arbiter, and the master view belongs to its environment.
interface rnd_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic                     flush_i;
  logic [1:0]               rm_i;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       req_sign_i;
  logic [NUM_REQ*31-1:0]    req_value_i;
  logic [NUM_REQ*2-1:0]     req_guard_i;
  logic [NUM_REQ*TAG_W-1:0] req_tag_i;
  logic                     rnd_sign_o;
  logic [30:0]              rnd_value_o;
  logic [1:0]               rnd_guard_o;
  logic [1:0]               rnd_mode_o;
  logic [31:0]              rnd_result_i;
  logic                     rnd_inf_i;
  logic                     res_valid_o;
  logic                     res_ready_i;
  logic [31:0]              res_data_o;
  logic                     res_sign_o;
  logic                     res_inf_o;
  logic [SRC_W-1:0]         res_src_o;
  logic [TAG_W-1:0]         res_tag_o;
  logic                     busy_o;

  modport slave (
    input  flush_i, rm_i, req_valid_i, req_sign_i, req_value_i, req_guard_i, req_tag_i,
    input  rnd_result_i, rnd_inf_i, res_ready_i,
    output req_ready_o, rnd_sign_o, rnd_value_o, rnd_guard_o, rnd_mode_o,
    output res_valid_o, res_data_o, res_sign_o, res_inf_o, res_src_o, res_tag_o, busy_o
  );

  modport master (
    output flush_i, rm_i, req_valid_i, req_sign_i, req_value_i, req_guard_i, req_tag_i,
    output rnd_result_i, rnd_inf_i, res_ready_i,
    input  req_ready_o, rnd_sign_o, rnd_value_o, rnd_guard_o, rnd_mode_o,
    input  res_valid_o, res_data_o, res_sign_o, res_inf_o, res_src_o, res_tag_o, busy_o
  );
endinterface

// File: rtl/rnd_share_arbiter.sv
// Round-robin arbiter sharing one combinational FP rounder among NUM_REQ producers.
// S1 holds the winning operand and feeds the rounder, and S2 captures the rounded result.
module rnd_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic                clk_i,
  input logic                rst_ni,
  rnd_share_arbiter_if.slave bus
);
  logic             vld_p1, vld_p2;
  logic [SRC_W-1:0] last;
  logic [SRC_W-1:0] win, cand;
  logic             found, grant, s2_take, s1_free;

  logic             sign_p1;
  logic [30:0]      value_p1;
  logic [1:0]       guard_p1;
  logic [1:0]       mode_p1;
  logic [TAG_W-1:0] tag_p1;
  logic [SRC_W-1:0] src_p1;

  logic [31:0]      data_p2;
  logic             inf_p2;
  logic             sign_p2;
  logic [TAG_W-1:0] tag_p2;
  logic [SRC_W-1:0] src_p2;

  assign s2_take = vld_p1 & (~vld_p2 | bus.res_ready_i);
  assign s1_free = ~vld_p1 | s2_take;

  // Scan downward so that the nearest valid requester after last is the one kept.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = SRC_W'((int'(last) + k) % NUM_REQ);
      if (bus.req_valid_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign grant = found & s1_free & ~bus.flush_i;

  always_comb begin
    bus.req_ready_o = '0;
    if (grant) bus.req_ready_o[win] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      last   <= SRC_W'(NUM_REQ - 1);
    end else if (bus.flush_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= grant | (vld_p1 & ~s2_take);
      vld_p2 <= s2_take | (vld_p2 & ~bus.res_ready_i);
      if (grant) last <= win;
    end
  end

  // ---- Stage S1: the registered winner drives the external rounder ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_p1  <= 1'b0;
      value_p1 <= '0;
      guard_p1 <= '0;
      mode_p1  <= '0;
      tag_p1   <= '0;
      src_p1   <= '0;
    end else if (grant) begin
      sign_p1  <= bus.req_sign_i[win];
      value_p1 <= bus.req_value_i[31*win +: 31];
      guard_p1 <= bus.req_guard_i[2*win +: 2];
      mode_p1  <= bus.rm_i;
      tag_p1   <= bus.req_tag_i[TAG_W*win +: TAG_W];
      src_p1   <= win;
    end
  end

  assign bus.rnd_sign_o  = sign_p1;
  assign bus.rnd_value_o = value_p1;
  assign bus.rnd_guard_o = guard_p1;
  assign bus.rnd_mode_o  = mode_p1;

  // ---- Stage S2: captures the rounder output and holds it until consumed ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_p2 <= '0;
      inf_p2  <= 1'b0;
      sign_p2 <= 1'b0;
      tag_p2  <= '0;
      src_p2  <= '0;
    end else if (s2_take) begin
      data_p2 <= bus.rnd_result_i;
      inf_p2  <= bus.rnd_inf_i;
      sign_p2 <= sign_p1;
      tag_p2  <= tag_p1;
      src_p2  <= src_p1;
    end
  end

  assign bus.res_valid_o = vld_p2;
  assign bus.res_data_o  = data_p2;
  assign bus.res_inf_o   = inf_p2;
  assign bus.res_sign_o  = sign_p2;
  assign bus.res_tag_o   = tag_p2;
  assign bus.res_src_o   = src_p2;
  assign bus.busy_o      = vld_p1 | vld_p2;
endmodule

// File: tb/tb_rnd_share_arbiter.sv
// Directed bench for rnd_share_arbiter with a behavioural rounder on the rnd_* ports.
// Expected results are queued at issue time, and a monitor pops them as results are consumed.
module tb_rnd_share_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 4;
  localparam int SRC_W   = 1;

  typedef struct packed {
    logic [31:0]      data;
    logic             inf;
    logic             sign;
    logic [SRC_W-1:0] src;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t act_r, exp_r;
  logic rnd_inc;

  always #5 clk = ~clk;

  rnd_share_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .SRC_W(SRC_W)) bus ();

  rnd_share_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .SRC_W(SRC_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Rounder: guard is {round, sticky}; the carry out of the 31-bit value lands in bit 31.
  always_comb begin
    rnd_inc = 1'b0;
    case (bus.rnd_mode_o)
      2'b00:   rnd_inc = 1'b0;
      2'b01:   rnd_inc = bus.rnd_guard_o[1] & (bus.rnd_guard_o[0] | bus.rnd_value_o[0]);
      2'b10:   rnd_inc = ~bus.rnd_sign_o & (|bus.rnd_guard_o);
      default: rnd_inc = bus.rnd_sign_o & (|bus.rnd_guard_o);
    endcase
  end
  assign bus.rnd_result_i = {1'b0, bus.rnd_value_o} + {31'd0, rnd_inc};
  assign bus.rnd_inf_i    = bus.rnd_result_i[31];

  always @(negedge clk) begin
    if (rst_n && bus.res_valid_o && bus.res_ready_i) begin
      act_r = {bus.res_data_o, bus.res_inf_o, bus.res_sign_o, bus.res_src_o, bus.res_tag_o};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got=%h (nothing expected)", act_r);
      end else begin
        exp_r = sb.pop_front();
        if (act_r !== exp_r) begin
          errors++;
          $display("FAIL result got data=%h inf=%b sign=%b src=%0d tag=%0d exp data=%h inf=%b sign=%b src=%0d tag=%0d",
                   act_r.data, act_r.inf, act_r.sign, act_r.src, act_r.tag,
                   exp_r.data, exp_r.inf, exp_r.sign, exp_r.src, exp_r.tag);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic sign, input logic [30:0] value,
                         input logic [1:0] guard, input logic [TAG_W-1:0] tag);
    bus.req_sign_i[idx]              = sign;
    bus.req_value_i[31*idx +: 31]    = value;
    bus.req_guard_i[2*idx +: 2]      = guard;
    bus.req_tag_i[TAG_W*idx +: TAG_W] = tag;
  endtask

  task automatic push_exp(input int idx, input logic sign, input logic [TAG_W-1:0] tag,
                          input logic [31:0] data, input logic inf);
    exp_t e;
    e.data = data;
    e.inf  = inf;
    e.sign = sign;
    e.src  = SRC_W'(idx);
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the grant edge.
  task automatic issue(input int idx, input logic sign, input logic [30:0] value,
                       input logic [1:0] guard, input logic [1:0] rm, input logic [TAG_W-1:0] tag,
                       input logic [31:0] exp_data, input logic exp_inf, input logic push);
    int n;
    if (push) push_exp(idx, sign, tag, exp_data, exp_inf);
    set_req(idx, sign, value, guard, tag);
    bus.rm_i             = rm;
    bus.req_valid_i[idx] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready_o[idx] && n < 40);
    check("grant_wait", {63'd0, bus.req_ready_o[idx]}, 64'd1);
    @(posedge clk); #1;
    bus.req_valid_i[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy_o) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n           = 1'b0;
    bus.flush_i     = 1'b0;
    bus.rm_i        = 2'b00;
    bus.req_valid_i = '0;
    bus.req_sign_i  = '0;
    bus.req_value_i = '0;
    bus.req_guard_i = '0;
    bus.req_tag_i   = '0;
    bus.res_ready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_res", {21'd0, bus.res_valid_o, bus.busy_o, bus.req_ready_o, bus.res_data_o,
                        bus.res_inf_o, bus.res_sign_o, bus.res_src_o, bus.res_tag_o}, 64'd0);
    check("reset_rnd", {28'd0, bus.rnd_sign_o, bus.rnd_value_o, bus.rnd_guard_o, bus.rnd_mode_o}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op, round to nearest even, latency grant+2
    issue(0, 1'b0, 31'h3F800001, 2'b10, 2'b01, 4'd5, 32'h3F800002, 1'b0, 1'b1);
    @(negedge clk);
    check("t1_lat_n1", {63'd0, bus.res_valid_o}, 64'd0);
    check("t1_rnd_value", {33'd0, bus.rnd_value_o}, 64'h3F800001);
    @(negedge clk);
    check("t1_lat_n2", {63'd0, bus.res_valid_o}, 64'd1);
    @(posedge clk); #1;
    wait_drain();

    // Truncate, with rm_i changing after the grant
    issue(1, 1'b0, 31'h3F800001, 2'b10, 2'b00, 4'd6, 32'h3F800001, 1'b0, 1'b1);
    bus.rm_i = 2'b01;
    @(negedge clk);
    check("t2_mode_held", {62'd0, bus.rnd_mode_o}, 64'd0);
    @(posedge clk); #1;
    wait_drain();

    // Fairness: both requesters valid for six grants
    for (int g = 0; g < 6; g++) begin
      if (g % 2 == 0) push_exp(0, 1'b0, 4'd1, 32'h3F800000, 1'b0);
      else            push_exp(1, 1'b1, 4'd2, 32'h3F800000, 1'b0);
    end
    set_req(0, 1'b0, 31'h3F800000, 2'b00, 4'd1);
    set_req(1, 1'b1, 31'h3F800000, 2'b00, 4'd2);
    bus.rm_i        = 2'b01;
    bus.req_valid_i = 2'b11;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      check("fair_grant", {62'd0, bus.req_ready_o}, (g % 2 == 0) ? 64'd1 : 64'd2);
    end
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
    wait_drain();

    // Backpressure: third op stalls while S1 and S2 are full
    bus.res_ready_i = 1'b0;
    issue(0, 1'b0, 31'h3F800001, 2'b10, 2'b01, 4'd1, 32'h3F800002, 1'b0, 1'b1);
    issue(0, 1'b0, 31'h40000003, 2'b01, 2'b10, 4'd2, 32'h40000004, 1'b0, 1'b1);
    push_exp(0, 1'b0, 4'd3, 32'h40000003, 1'b0);
    set_req(0, 1'b0, 31'h40000003, 2'b01, 4'd3);
    bus.rm_i           = 2'b11;
    bus.req_valid_i[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_ready_low", {62'd0, bus.req_ready_o}, 64'd0);
      check("bp_hold_data", {32'd0, bus.res_data_o}, 64'h3F800002);
    end
    check("bp_res_valid", {63'd0, bus.res_valid_o}, 64'd1);
    @(posedge clk); #1;
    bus.res_ready_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready_o[0] && n < 40);
    check("bp_grant3", {63'd0, bus.req_ready_o[0]}, 64'd1);
    @(posedge clk); #1;
    bus.req_valid_i[0] = 1'b0;
    wait_drain();

    // Overflow into bit 31
    issue(0, 1'b0, 31'h7F7FFFFF, 2'b11, 2'b01, 4'd7, 32'h7F800000, 1'b0, 1'b1);
    issue(0, 1'b1, 31'h7FFFFFFF, 2'b11, 2'b01, 4'd8, 32'h80000000, 1'b1, 1'b1);
    wait_drain();

    // Flush with both stages full, then round-robin resumes after requester 0
    bus.res_ready_i = 1'b0;
    issue(0, 1'b0, 31'h00000010, 2'b00, 2'b01, 4'd11, 32'h0, 1'b0, 1'b0);
    issue(0, 1'b0, 31'h00000020, 2'b00, 2'b01, 4'd12, 32'h0, 1'b0, 1'b0);
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_busy_before", {63'd0, bus.busy_o}, 64'd1);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_busy_after", {63'd0, bus.busy_o}, 64'd0);
    check("flush_no_valid", {63'd0, bus.res_valid_o}, 64'd0);
    @(posedge clk); #1;
    bus.res_ready_i = 1'b1;
    push_exp(1, 1'b0, 4'd9, 32'h3F800002, 1'b0);
    push_exp(0, 1'b0, 4'd10, 32'h3F800001, 1'b0);
    set_req(1, 1'b0, 31'h3F800001, 2'b11, 4'd9);
    set_req(0, 1'b0, 31'h3F800001, 2'b01, 4'd10);
    bus.rm_i        = 2'b01;
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    check("post_flush_rr1", {62'd0, bus.req_ready_o}, 64'd2);
    @(posedge clk); #1;
    bus.req_valid_i[1] = 1'b0;
    @(negedge clk);
    check("post_flush_rr0", {62'd0, bus.req_ready_o}, 64'd1);
    @(posedge clk); #1;
    bus.req_valid_i[0] = 1'b0;
    wait_drain();

    // Asynchronous reset mid-stream
    bus.res_ready_i = 1'b0;
    issue(1, 1'b1, 31'h12345678, 2'b11, 2'b10, 4'd13, 32'h0, 1'b0, 1'b0);
    issue(0, 1'b1, 31'h23456789, 2'b11, 2'b11, 4'd14, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_res", {21'd0, bus.res_valid_o, bus.busy_o, bus.req_ready_o, bus.res_data_o,
                       bus.res_inf_o, bus.res_sign_o, bus.res_src_o, bus.res_tag_o}, 64'd0);
    check("arst_rnd", {28'd0, bus.rnd_sign_o, bus.rnd_value_o, bus.rnd_guard_o, bus.rnd_mode_o}, 64'd0);
    @(negedge clk);
    rst_n           = 1'b1;
    bus.res_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("arst_no_result", {63'd0, bus.res_valid_o}, 64'd0);
    end
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
